// File: rtl/spi_cmd_arbiter.sv
// rtl/spi_cmd_arbiter.sv - round-robin arbiter sharing one SPI flash command engine
// between two requesters, with read-byte forwarding and a hung-command watchdog.
module spi_cmd_arbiter #(
  parameter int unsigned TIMEOUT_CYC = 1000000,
  parameter logic [3:0]  IDLE_TYPE   = 4'b0000
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        a_req,
  input  logic [3:0]  a_type,
  input  logic [7:0]  a_cmd,
  input  logic [23:0] a_addr,
  output logic        a_gnt,
  output logic        a_done,
  output logic        a_err,
  input  logic        b_req,
  input  logic [3:0]  b_type,
  input  logic [7:0]  b_cmd,
  input  logic [23:0] b_addr,
  output logic        b_gnt,
  output logic        b_done,
  output logic        b_err,
  output logic [7:0]  rd_data,
  output logic        rd_valid_a,
  output logic        rd_valid_b,
  output logic [3:0]  cmd_type,
  output logic [7:0]  flash_cmd,
  output logic [23:0] flash_addr,
  input  logic        Done_Sig,
  input  logic [7:0]  mydata_o,
  input  logic        myvalid_o
);

  localparam int TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RELEASE} state_t;

  state_t        state;
  logic          port;   // port being served: 0 = A, 1 = B
  logic          last;   // port served most recently: 0 = A, 1 = B
  logic [TW-1:0] timer;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= S_IDLE;
      port       <= 1'b0;
      last       <= 1'b1;
      timer      <= '0;
      a_gnt      <= 1'b0;
      b_gnt      <= 1'b0;
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      rd_data    <= 8'h00;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      cmd_type   <= IDLE_TYPE;
      flash_cmd  <= 8'h00;
      flash_addr <= 24'h000000;
    end else begin
      a_done     <= 1'b0;
      b_done     <= 1'b0;
      a_err      <= 1'b0;
      b_err      <= 1'b0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;

      // Engine read bytes only belong to a command while it is in flight.
      if (state == S_ISSUE || state == S_WAIT) begin
        if (myvalid_o) rd_data <= mydata_o;
        rd_valid_a <= myvalid_o & ~port;
        rd_valid_b <= myvalid_o & port;
      end

      case (state)
        S_IDLE: begin
          if (a_req || b_req) begin
            if (a_req && (!b_req || last)) begin
              port       <= 1'b0;
              cmd_type   <= a_type;
              flash_cmd  <= a_cmd;
              flash_addr <= a_addr;
              a_gnt      <= 1'b1;
            end else begin
              port       <= 1'b1;
              cmd_type   <= b_type;
              flash_cmd  <= b_cmd;
              flash_addr <= b_addr;
              b_gnt      <= 1'b1;
            end
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (Done_Sig || timer == T_LAST) begin
            if (Done_Sig) begin
              a_done <= ~port;
              b_done <= port;
            end else begin
              a_err <= ~port;
              b_err <= port;
            end
            cmd_type <= IDLE_TYPE;
            a_gnt    <= 1'b0;
            b_gnt    <= 1'b0;
            last     <= port;
            state    <= S_RELEASE;
          end else if (timer != '1) begin
            timer <= timer + TW'(1);
          end
        end
        S_RELEASE: begin
          // A stretched Done_Sig must not complete the next command.
          if (!Done_Sig) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
